// File: rtl/axi_ad9371_rx_os_capture_ctrl.sv
// axi_ad9371_rx_os_capture_ctrl
//
// Capture sequencer for the AD9371 observation-receiver path. Arms on a
// command, optionally waits for a trigger, forwards exactly the latched
// number of valid 64-bit I/Q words to the DMA, then stops in DONE until
// re-armed or aborted.
//
// Ports:
//   adc_os_clk, adc_os_rst    clock, asynchronous active-high reset
//   cfg_arm, cfg_abort        single-cycle arm / abort requests
//   cfg_length, cfg_trig_mode capture length and trigger mode (latched on arm)
//   trig_in                   trigger, synchronous to adc_os_clk
//   adc_os_valid/data/dovf    channel sample stream and DMA overflow
//   dma_valid, dma_data       registered forwarded samples
//   status_*                  busy, done, sticky overflow/timeout, count
//
// Optional feature: define AD9371_RX_OS_CAPTURE_TIMEOUT_EN to abandon a
// trigger wait after TIMEOUT_CYCLES cycles (sets status_timeout). Without
// it WAIT_TRIG waits indefinitely and status_timeout is tied low.
//
// state     | meaning
// ----------+-----------------------------------------------
// IDLE      | not armed; waiting for an arm with length != 0
// WAIT_TRIG | armed; waiting for rising edge or high level
// CAPTURE   | forwarding valid samples until count == length
// DONE      | capture complete; holds until arm or abort

module axi_ad9371_rx_os_capture_ctrl #(
  parameter int LENGTH_WIDTH   = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                    adc_os_clk,
  input  logic                    adc_os_rst,
  input  logic                    cfg_arm,
  input  logic                    cfg_abort,
  input  logic [LENGTH_WIDTH-1:0] cfg_length,
  input  logic [1:0]              cfg_trig_mode,
  input  logic                    trig_in,
  input  logic                    adc_os_valid,
  input  logic [63:0]             adc_os_data,
  input  logic                    adc_os_dovf,
  output logic                    dma_valid,
  output logic [63:0]             dma_data,
  output logic                    status_busy,
  output logic                    status_done,
  output logic                    status_ovf,
  output logic                    status_timeout,
  output logic [LENGTH_WIDTH-1:0] status_count
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_TRIG = 2'd1,
    ST_CAPTURE   = 2'd2,
    ST_DONE      = 2'd3
  } state_t;

  state_t                  r_state;
  logic [LENGTH_WIDTH-1:0] r_len;
  logic [LENGTH_WIDTH-1:0] r_count;
  logic [1:0]              r_mode;
  logic                    r_trig_d;
  logic                    r_ovf;
  logic                    r_dma_valid;
  logic [63:0]             r_dma_data;

  logic w_trig_rise;
  logic w_arm_ok;
  logic w_arm_imm;
  logic w_arm_trig;
  logic w_wait_trig;
  logic w_last;

`ifdef AD9371_RX_OS_CAPTURE_TIMEOUT_EN
  // Down-counter: loaded on entry to WAIT_TRIG, terminal count at zero,
  // so WAIT_TRIG lasts exactly TIMEOUT_CYCLES cycles without a trigger.
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] r_wait;
  logic          r_timeout;
`endif

  assign w_trig_rise = trig_in & ~r_trig_d;

  // Modes 00 and 11 are both immediate.
  assign w_arm_imm  = (cfg_trig_mode[0] == cfg_trig_mode[1]);
  // A trigger already qualifying on the arm cycle skips WAIT_TRIG so that a
  // held level starts CAPTURE the cycle after arm. A level held before arm
  // never shows a rising edge because trig_d tracks it in every state.
  assign w_arm_trig = ((cfg_trig_mode == 2'b01) & w_trig_rise) |
                      ((cfg_trig_mode == 2'b10) & trig_in);
  assign w_wait_trig = ((r_mode == 2'b01) & w_trig_rise) |
                       ((r_mode == 2'b10) & trig_in);

  assign w_arm_ok = cfg_arm && (cfg_length != '0) &&
                    ((r_state == ST_IDLE) || (r_state == ST_DONE));

  // count < length always holds in CAPTURE, so count+1 cannot wrap.
  assign w_last = ((r_count + LENGTH_WIDTH'(1)) == r_len);

  always_ff @(posedge adc_os_clk or posedge adc_os_rst) begin
    if (adc_os_rst) begin
      r_state     <= ST_IDLE;
      r_len       <= '0;
      r_count     <= '0;
      r_mode      <= 2'b00;
      r_trig_d    <= 1'b0;
      r_ovf       <= 1'b0;
      r_dma_valid <= 1'b0;
      r_dma_data  <= '0;
`ifdef AD9371_RX_OS_CAPTURE_TIMEOUT_EN
      r_wait      <= '0;
      r_timeout   <= 1'b0;
`endif
    end else begin
      r_trig_d    <= trig_in;
      r_dma_valid <= 1'b0;
      if (cfg_abort) begin
        // Abort overrides any simultaneous arm; count and flags are kept.
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE, ST_DONE: begin
            if (w_arm_ok) begin
              r_len   <= cfg_length;
              r_mode  <= cfg_trig_mode;
              r_count <= '0;
              r_ovf   <= 1'b0;
`ifdef AD9371_RX_OS_CAPTURE_TIMEOUT_EN
              r_timeout <= 1'b0;
              r_wait    <= TW'(TIMEOUT_CYCLES - 1);
`endif
              if (w_arm_imm || w_arm_trig) begin
                r_state <= ST_CAPTURE;
              end else begin
                r_state <= ST_WAIT_TRIG;
              end
            end
          end
          ST_WAIT_TRIG: begin
            // Samples arriving while waiting are dropped.
            if (w_wait_trig) begin
              r_state <= ST_CAPTURE;
            end
`ifdef AD9371_RX_OS_CAPTURE_TIMEOUT_EN
            else if (r_wait == '0) begin
              r_state   <= ST_IDLE;
              r_timeout <= 1'b1;
            end else begin
              r_wait <= r_wait - TW'(1);
            end
`endif
          end
          ST_CAPTURE: begin
            if (adc_os_dovf) begin
              r_ovf <= 1'b1;
            end
            if (adc_os_valid) begin
              r_dma_valid <= 1'b1;
              r_dma_data  <= adc_os_data;
              r_count     <= r_count + LENGTH_WIDTH'(1);
              if (w_last) begin
                r_state <= ST_DONE;
              end
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign dma_valid    = r_dma_valid;
  assign dma_data     = r_dma_data;
  assign status_busy  = (r_state == ST_WAIT_TRIG) || (r_state == ST_CAPTURE);
  assign status_done  = (r_state == ST_DONE);
  assign status_ovf   = r_ovf;
  assign status_count = r_count;
`ifdef AD9371_RX_OS_CAPTURE_TIMEOUT_EN
  assign status_timeout = r_timeout;
`else
  assign status_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_axi_ad9371_rx_os_capture_ctrl.sv
// Testbench for axi_ad9371_rx_os_capture_ctrl: per-cycle vector table plus
// hand-written sequences for trigger timeout and asynchronous reset.
`timescale 1ns/1ps

module tb_axi_ad9371_rx_os_capture_ctrl;

  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_arm, cfg_abort;
  logic [LW-1:0] cfg_length;
  logic [1:0]    cfg_trig_mode;
  logic          trig_in, adc_os_valid, adc_os_dovf;
  logic [63:0]   adc_os_data;
  logic          dma_valid;
  logic [63:0]   dma_data;
  logic          status_busy, status_done, status_ovf, status_timeout;
  logic [LW-1:0] status_count;

  always #5 clk = ~clk;

  axi_ad9371_rx_os_capture_ctrl #(
    .LENGTH_WIDTH   (LW),
    .TIMEOUT_CYCLES (20)
  ) dut (
    .adc_os_clk     (clk),
    .adc_os_rst     (rst),
    .cfg_arm        (cfg_arm),
    .cfg_abort      (cfg_abort),
    .cfg_length     (cfg_length),
    .cfg_trig_mode  (cfg_trig_mode),
    .trig_in        (trig_in),
    .adc_os_valid   (adc_os_valid),
    .adc_os_data    (adc_os_data),
    .adc_os_dovf    (adc_os_dovf),
    .dma_valid      (dma_valid),
    .dma_data       (dma_data),
    .status_busy    (status_busy),
    .status_done    (status_done),
    .status_ovf     (status_ovf),
    .status_timeout (status_timeout),
    .status_count   (status_count)
  );

  typedef struct {
    logic          arm, abort;
    logic [LW-1:0] len;
    logic [1:0]    mode;
    logic          trig, valid;
    logic [63:0]   data;
    logic          dovf;
    logic          e_dv;
    logic [63:0]   e_data;
    logic          e_busy, e_done, e_ovf;
    logic [LW-1:0] e_cnt;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic vec_t mk(logic arm, logic abort, int len, int mode,
                              logic trig, logic valid, logic [63:0] data,
                              logic dovf, logic e_dv, logic [63:0] e_data,
                              logic e_busy, logic e_done, logic e_ovf,
                              int e_cnt);
    vec_t v;
    v.arm = arm; v.abort = abort; v.len = LW'(len); v.mode = 2'(mode);
    v.trig = trig; v.valid = valid; v.data = data; v.dovf = dovf;
    v.e_dv = e_dv; v.e_data = e_data; v.e_busy = e_busy;
    v.e_done = e_done; v.e_ovf = e_ovf; v.e_cnt = LW'(e_cnt);
    return v;
  endfunction

  task automatic drive(input vec_t v);
    cfg_arm = v.arm; cfg_abort = v.abort; cfg_length = v.len;
    cfg_trig_mode = v.mode; trig_in = v.trig; adc_os_valid = v.valid;
    adc_os_data = v.data; adc_os_dovf = v.dovf;
  endtask

  task automatic idle_inputs();
    cfg_arm = 0; cfg_abort = 0; cfg_length = '0; cfg_trig_mode = 2'b00;
    trig_in = 0; adc_os_valid = 0; adc_os_data = '0; adc_os_dovf = 0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_vec(input int i, input vec_t v);
    logic bad;
    n_vec++;
    bad = (dma_valid !== v.e_dv) || (status_busy !== v.e_busy) ||
          (status_done !== v.e_done) || (status_ovf !== v.e_ovf) ||
          (status_timeout !== 1'b0) || (status_count !== v.e_cnt) ||
          (v.e_dv && (dma_data !== v.e_data));
    if (bad) begin
      n_bad++;
      $display("FAIL vec%0d: got dv=%b data=%h busy=%b done=%b ovf=%b tmo=%b cnt=%0d; want dv=%b data=%h busy=%b done=%b ovf=%b tmo=0 cnt=%0d",
               i, dma_valid, dma_data, status_busy, status_done, status_ovf,
               status_timeout, status_count, v.e_dv, v.e_data, v.e_busy,
               v.e_done, v.e_ovf, v.e_cnt);
    end
  endtask

  task automatic check_val(input string name, input logic [63:0] act,
                           input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  initial begin
    int n;
    idle_inputs();
    rst = 1'b1;
    #2;
    check_val("reset_outputs_before_clock",
              {dma_valid, status_busy, status_done, status_ovf, status_timeout,
               status_count}, '0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    step();
    check_val("reset_idle", {dma_valid, status_busy, status_done, status_ovf,
                             status_timeout, status_count}, '0);
    check_val("reset_data", dma_data, '0);

    // immediate capture, length 4 (sample on the arm cycle is not eligible)
    tbl.push_back(mk(1,0,4,0, 0,1,64'h0F,0, 0,0,     1,0,0,0));
    tbl.push_back(mk(0,0,0,0, 0,1,64'h10,0, 1,64'h10,1,0,0,1));
    tbl.push_back(mk(0,0,0,0, 0,1,64'h11,0, 1,64'h11,1,0,0,2));
    tbl.push_back(mk(0,0,0,0, 0,1,64'h12,0, 1,64'h12,1,0,0,3));
    tbl.push_back(mk(0,0,0,0, 0,1,64'h13,0, 1,64'h13,0,1,0,4));
    tbl.push_back(mk(0,0,0,0, 0,1,64'h14,0, 0,0,     0,1,0,4));
    tbl.push_back(mk(0,0,0,0, 0,0,64'h00,0, 0,0,     0,1,0,4));
    // rising-edge mode, trig already high at arm
    tbl.push_back(mk(0,0,0,0, 1,0,64'h00,0, 0,0,     0,1,0,4));
    tbl.push_back(mk(1,0,3,1, 1,0,64'h00,0, 0,0,     1,0,0,0));
    tbl.push_back(mk(0,0,0,0, 1,1,64'h20,0, 0,0,     1,0,0,0));
    tbl.push_back(mk(0,0,0,0, 0,1,64'h21,0, 0,0,     1,0,0,0));
    tbl.push_back(mk(0,0,0,0, 1,1,64'h22,0, 0,0,     1,0,0,0));
    tbl.push_back(mk(0,0,0,0, 1,1,64'h23,0, 1,64'h23,1,0,0,1));
    tbl.push_back(mk(0,0,0,0, 1,1,64'h24,0, 1,64'h24,1,0,0,2));
    tbl.push_back(mk(0,0,0,0, 1,1,64'h25,0, 1,64'h25,0,1,0,3));
    tbl.push_back(mk(0,0,0,0, 0,0,64'h00,0, 0,0,     0,1,0,3));
    // mode 11 immediate, gapped valid 1,0,1,1 with an overflow pulse
    tbl.push_back(mk(1,0,3,3, 0,0,64'h00,0, 0,0,     1,0,0,0));
    tbl.push_back(mk(0,0,0,0, 0,1,64'hDEADBEEF_00000030,0,
                                        1,64'hDEADBEEF_00000030,1,0,0,1));
    tbl.push_back(mk(0,0,0,0, 0,0,64'h00,1, 0,0,     1,0,1,1));
    tbl.push_back(mk(0,0,0,0, 0,1,64'h31,0, 1,64'h31,1,0,1,2));
    tbl.push_back(mk(0,0,0,0, 0,1,64'h32,0, 1,64'h32,0,1,1,3));
    tbl.push_back(mk(0,0,0,0, 0,0,64'h00,0, 0,0,     0,1,1,3));
    // zero-length arm ignored; next arm clears ovf; arm while busy ignored
    tbl.push_back(mk(1,0,0,0, 0,0,64'h00,0, 0,0,     0,1,1,3));
    tbl.push_back(mk(1,0,8,0, 0,0,64'h00,0, 0,0,     1,0,0,0));
    tbl.push_back(mk(0,0,0,0, 0,1,64'h40,0, 1,64'h40,1,0,0,1));
    tbl.push_back(mk(1,0,2,0, 0,1,64'h41,0, 1,64'h41,1,0,0,2));
    // abort after 2 of 8, then abort together with arm
    tbl.push_back(mk(0,1,0,0, 0,1,64'h42,0, 0,0,     0,0,0,2));
    tbl.push_back(mk(0,0,0,0, 0,1,64'h43,0, 0,0,     0,0,0,2));
    tbl.push_back(mk(1,1,4,0, 0,1,64'h44,0, 0,0,     0,0,0,2));
    tbl.push_back(mk(0,0,0,0, 0,0,64'h00,1, 0,0,     0,0,0,2));
    // level mode: level high at arm goes straight to capture
    tbl.push_back(mk(1,0,2,2, 1,0,64'h00,0, 0,0,     1,0,0,0));
    tbl.push_back(mk(0,0,0,0, 0,1,64'h50,0, 1,64'h50,1,0,0,1));
    tbl.push_back(mk(0,0,0,0, 0,1,64'h51,0, 1,64'h51,0,1,0,2));
    // level mode: wait, then level arrives
    tbl.push_back(mk(1,0,1,2, 0,0,64'h00,0, 0,0,     1,0,0,0));
    tbl.push_back(mk(0,0,0,0, 0,1,64'h60,0, 0,0,     1,0,0,0));
    tbl.push_back(mk(0,0,0,0, 1,0,64'h00,0, 0,0,     1,0,0,0));
    tbl.push_back(mk(0,0,0,0, 1,1,64'h61,0, 1,64'h61,0,1,0,1));
    tbl.push_back(mk(0,0,0,0, 0,0,64'h00,0, 0,0,     0,1,0,1));

    foreach (tbl[i]) begin
      drive(tbl[i]);
      step();
      check_vec(i, tbl[i]);
    end
    idle_inputs();

    // trigger wait with no trigger
    cfg_arm = 1; cfg_length = LW'(5); cfg_trig_mode = 2'b01;
    step();
    idle_inputs();
    check_val("twait_busy", {status_busy, status_done}, 2'b10);
`ifdef AD9371_RX_OS_CAPTURE_TIMEOUT_EN
    n = 0;
    while (status_busy && n < 100) begin
      step();
      n++;
    end
    check_val("timeout_cycles", 64'(n), 64'd20);
    check_val("timeout_state", {status_busy, status_done, status_timeout},
              3'b001);
    cfg_arm = 1; cfg_length = LW'(2); cfg_trig_mode = 2'b00;
    step();
    idle_inputs();
    check_val("timeout_cleared_on_arm", {status_busy, status_timeout}, 2'b10);
    cfg_abort = 1;
    step();
    idle_inputs();
`else
    n = 0;
    repeat (40) begin
      step();
      n++;
    end
    check_val("wait_indefinite", {status_busy, status_timeout}, 2'b10);
    cfg_abort = 1;
    step();
    idle_inputs();
    check_val("wait_abort", {status_busy, status_done}, 2'b00);
`endif

    // asynchronous reset mid-capture
    cfg_arm = 1; cfg_length = LW'(10); cfg_trig_mode = 2'b00;
    step();
    idle_inputs();
    adc_os_valid = 1; adc_os_data = 64'h70;
    step();
    adc_os_data = 64'h71;
    adc_os_dovf = 1;
    step();
    check_val("pre_reset", {dma_valid, status_busy, status_ovf, status_count},
              {3'b111, LW'(2)});
    #2 rst = 1'b1;
    #1;
    check_val("async_reset_ctrl",
              {dma_valid, status_busy, status_done, status_ovf, status_timeout,
               status_count}, '0);
    check_val("async_reset_data", dma_data, '0);
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
    cfg_arm = 1; cfg_length = LW'(1); cfg_trig_mode = 2'b00;
    step();
    idle_inputs();
    adc_os_valid = 1; adc_os_data = 64'hCAFE_0000_0000_0080;
    step();
    idle_inputs();
    check_val("post_reset_capture",
              {dma_valid, status_busy, status_done, status_count},
              {3'b101, LW'(1)});
    check_val("post_reset_data", dma_data, 64'hCAFE_0000_0000_0080);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/axi_ad9371_rx_os_capture_ctrl.md
# axi_ad9371_rx_os_capture_ctrl

Capture sequencer for the AD9371 observation-receiver datapath. It sits between the rx_os channel outputs and the DMA, in the `adc_os_clk` domain. It arms on command, optionally waits for a trigger, forwards exactly `cfg_length` valid 64-bit I/Q words to the DMA, then stops. It reports busy, done, overflow and count status for the processor register bank.

## Interface
Parameters:
- `LENGTH_WIDTH`, 16: width of the sample length and count.
- `TIMEOUT_CYCLES`, 65535: trigger-wait timeout in clock cycles. Used only with the timeout macro.

Ports:
- `adc_os_clk` in 1: the only clock.
- `adc_os_rst` in 1: reset, asynchronous, active-high.
- `cfg_arm` in 1: single-cycle arm request.
- `cfg_abort` in 1: single-cycle abort request.
- `cfg_length` in LENGTH_WIDTH: samples per capture, latched on arm.
- `cfg_trig_mode` in 2: latched on arm. 00 = immediate, 01 = trig_in rising edge, 10 = trig_in high level, 11 = immediate.
- `trig_in` in 1: trigger, synchronous to `adc_os_clk`.
- `adc_os_valid` in 1: sample valid from the channels.
- `adc_os_data` in 64: {Q[31:0], I[31:0]}.
- `adc_os_dovf` in 1: DMA overflow.
- `dma_valid` out 1: registered forwarded valid.
- `dma_data` out 64: registered forwarded data.
- `status_busy` out 1: high in WAIT_TRIG or CAPTURE.
- `status_done` out 1: high in DONE.
- `status_ovf` out 1: sticky; set by overflow during a capture.
- `status_timeout` out 1: sticky; set by a trigger-wait timeout.
- `status_count` out LENGTH_WIDTH: samples forwarded in the current or last capture.

## Operation
States: IDLE, WAIT_TRIG, CAPTURE, DONE.

- **Arm (IDLE or DONE):** `cfg_arm` with `cfg_length != 0` does the following.
  - Latches length and mode.
  - Clears count, `status_ovf` and `status_timeout`.
  - Goes to CAPTURE if the mode is immediate (00 or 11), otherwise to WAIT_TRIG.
- **Zero-length arm:** `cfg_arm` with `cfg_length == 0` is ignored. State and status are unchanged.
- **Arm while busy:** `cfg_arm` in WAIT_TRIG or CAPTURE is ignored.
- **Trigger detection:** `trig_d` is registered every cycle in all states. A rising edge is `trig_in & ~trig_d`.
  - A level held high before arm does not satisfy rising-edge mode.
  - A level held high does satisfy level mode; CAPTURE is entered the cycle after arm.
- **WAIT_TRIG:** a qualifying trigger moves to CAPTURE on the next cycle. Samples arriving in WAIT_TRIG are dropped.
- **CAPTURE:**
  - Each cycle with `adc_os_valid`: `dma_data` <= `adc_os_data`, `dma_valid` <= 1, count increments.
  - On the cycle the count reaches the latched length, go to DONE.
  - Later valids are dropped.
- **Overflow:** `adc_os_dovf` in CAPTURE sets `status_ovf`. The capture continues.
- **DONE:** holds until the next arm or abort.
- **Abort:** `cfg_abort` in any state goes to IDLE. Count and sticky flags are kept; done is not reached.
- **Abort with arm:** abort wins; the arm is discarded.
- **Count width:** `status_count` never exceeds the latched length. No wrap is possible, because length ≤ 2^LENGTH_WIDTH−1.

## Timing
- Reset values:
  - State: IDLE.
  - `dma_valid`: 0.
  - `dma_data`: 0.
  - All status outputs and `trig_d`: 0.
- Reset asserted mid-capture: outputs go to reset values immediately (asynchronously); operation resumes from IDLE.
- Arm at cycle t, immediate mode: state is CAPTURE at t+1; the first eligible sample is at t+1.
- Trigger edge at cycle t: CAPTURE at t+1.
- Data latency: `adc_os_valid` at cycle c gives `dma_valid`/`dma_data` at c+1. Exactly one output word per accepted input.
- Final sample at c: DONE at c+1, together with the last `dma_valid`. `dma_valid` is 0 from c+2.
- Abort at cycle t: a sample accepted at t−1 still appears at t. `dma_valid` is 0 from t+1; nothing is accepted at t.
- Status outputs are registered and update one cycle after the causing event.

## Configuration
- `AD9371_RX_OS_CAPTURE_TIMEOUT_EN` defined:
  - A wait counter, cleared on entry to WAIT_TRIG, increments every cycle in WAIT_TRIG.
  - On reaching `TIMEOUT_CYCLES`: go to IDLE and set `status_timeout`.
  - A trigger in the same cycle as the timeout wins (go to CAPTURE).
- `AD9371_RX_OS_CAPTURE_TIMEOUT_EN` undefined:
  - WAIT_TRIG waits indefinitely.
  - `status_timeout` is tied to 0; no counter logic exists.

## Test plan
- **Immediate capture:** mode 00, length 4, valid held high, data incrementing from 0x10 -> exactly 4 `dma_valid` pulses, data 0x10–0x13, `status_count`=4, DONE one cycle after the last accepted sample.
- **Rising-edge trigger:** mode 01, `trig_in` already high at arm -> stays in WAIT_TRIG. Drop then re-raise `trig_in` -> CAPTURE next cycle, length 3 forwarded.
- **Gapped valid plus overflow:** valid pattern 1,0,1,1 with one `adc_os_dovf` pulse, length 3 -> 3 outputs; `status_ovf`=1 and stays set until the next arm.
- **Abort boundaries:** abort after 2 of 8 samples -> IDLE, count=2, done=0. Abort and arm in the same cycle -> remains IDLE. Zero-length arm -> ignored.
- **Reset mid-capture:** assert `adc_os_rst` asynchronously mid-capture -> all outputs 0 without waiting for a clock edge; a new arm works afterwards.
- **Timeout (macro defined):** `TIMEOUT_CYCLES`=20, mode 01, no trigger -> IDLE with `status_timeout`=1 at 20 cycles.
